// File: rtl/irq_pend_ctrl_pkg.sv
// rtl/irq_pend_ctrl_pkg.sv - shared types and defaults for the interrupt pending/arbitration stage
package irq_pend_ctrl_pkg;

  localparam int IRQ_NUM_POW_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } irq_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - combinational lowest-index-wins priority encoder
module irq_prio_enc
  import irq_pend_ctrl_pkg::*;
#(
  parameter int IRQ_NUM_POW = IRQ_NUM_POW_DEF
) (
  input  logic [(2**IRQ_NUM_POW)-1:0] req_vec,
  output logic [IRQ_NUM_POW-1:0]      idx,
  output logic                        valid
);

  localparam int N = 2**IRQ_NUM_POW;

  // Scan high to low so the last hit, the lowest set index, is what remains.
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        idx   = IRQ_NUM_POW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_pend_ctrl.sv
// rtl/irq_pend_ctrl.sv - interrupt pending register and request/ack arbiter toward the core
// IRQ_PEND_CTRL_EDGE_DETECT_EN selects rising-edge external events; otherwise lines are level-sensitive.
module irq_pend_ctrl
  import irq_pend_ctrl_pkg::*;
#(
  parameter int IRQ_NUM_POW = IRQ_NUM_POW_DEF,
  parameter int TIMER_LINE  = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [(2**IRQ_NUM_POW)-1:0]   irq_en_bi,
  input  logic                          irq_timer_i,
  input  logic                          sgi_req_i,
  input  logic [IRQ_NUM_POW-1:0]        sgi_code_bi,
  input  logic [(2**IRQ_NUM_POW)-1:0]   irq_bi,
  output logic                          irq_req_o,
  output logic [IRQ_NUM_POW-1:0]        irq_code_bo,
  input  logic                          irq_ack_i,
  output logic [(2**IRQ_NUM_POW)-1:0]   irq_pend_bo
);

  localparam int N = 2**IRQ_NUM_POW;

  logic [N-1:0]           s1, s2;
  logic [N-1:0]           ext_set;
  logic [N-1:0]           set_vec;
  logic [N-1:0]           clr_vec;
  logic [N-1:0]           pend;
  logic [N-1:0]           cand;
  logic [IRQ_NUM_POW-1:0] win_idx;
  logic                   win_valid;
  irq_state_t             state;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= irq_bi;
      s2 <= s1;
    end
  end

`ifdef IRQ_PEND_CTRL_EDGE_DETECT_EN
  logic [N-1:0] s3;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s3 <= '0;
    end else begin
      s3 <= s2;
    end
  end

  assign ext_set = s2 & ~s3;
`else
  assign ext_set = s2;
`endif

  always_comb begin
    set_vec = ext_set;
    if (irq_timer_i) begin
      set_vec[TIMER_LINE] = 1'b1;
    end
    if (sgi_req_i) begin
      set_vec[sgi_code_bi] = 1'b1;
    end
  end

  always_comb begin
    clr_vec = '0;
    if (state == REQ && irq_ack_i) begin
      clr_vec[irq_code_bo] = 1'b1;
    end
  end

  // Sets are OR-ed in after the clear so a coincident event keeps the bit pending.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~clr_vec) | set_vec;
    end
  end

  assign cand = pend & irq_en_bi;

  irq_prio_enc #(
    .IRQ_NUM_POW (IRQ_NUM_POW)
  ) u_prio_enc (
    .req_vec (cand),
    .idx     (win_idx),
    .valid   (win_valid)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      irq_req_o   <= 1'b0;
      irq_code_bo <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_valid) begin
            irq_code_bo <= win_idx;
            irq_req_o   <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            irq_req_o <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          state <= IDLE;
        end
        default: begin
          irq_req_o <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign irq_pend_bo = pend;

endmodule

// File: tb/tb_irq_pend_ctrl.sv
// tb/tb_irq_pend_ctrl.sv - self-checking bench for irq_pend_ctrl with a cycle-level reference model
module tb_irq_pend_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [15:0] irq_en_bi = 16'h0000;
  logic        irq_timer_i = 1'b0;
  logic        sgi_req_i = 1'b0;
  logic [3:0]  sgi_code_bi = 4'd0;
  logic [15:0] irq_bi = 16'h0000;
  logic        irq_req_o;
  logic [3:0]  irq_code_bo;
  logic        irq_ack_i = 1'b0;
  logic [15:0] irq_pend_bo;

  int n_cmp = 0;
  int n_fail = 0;
  logic cmp_on = 1'b0;

  irq_pend_ctrl #(
    .IRQ_NUM_POW (4),
    .TIMER_LINE  (0)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .irq_en_bi   (irq_en_bi),
    .irq_timer_i (irq_timer_i),
    .sgi_req_i   (sgi_req_i),
    .sgi_code_bi (sgi_code_bi),
    .irq_bi      (irq_bi),
    .irq_req_o   (irq_req_o),
    .irq_code_bo (irq_code_bo),
    .irq_ack_i   (irq_ack_i),
    .irq_pend_bo (irq_pend_bo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: line history as a delay line, pending as a bit set,
  // service expressed as "earliest edge a new request may launch".
  logic [15:0] m_pend = '0;
  logic        m_req = 1'b0;
  int          m_code = 0;
  int          m_cyc = 0;
  int          m_hold = 0;
  logic [15:0] h1 = '0, h2 = '0, h3 = '0;

  always @(posedge clk or negedge rst_i) begin
    logic [15:0] ev;
    logic [15:0] sets;
    logic [15:0] avail;
    if (!rst_i) begin
      m_pend = '0; m_req = 1'b0; m_code = 0; m_cyc = 0; m_hold = 0;
      h1 = '0; h2 = '0; h3 = '0;
    end else begin
`ifdef IRQ_PEND_CTRL_EDGE_DETECT_EN
      ev = h2 & ~h3;
`else
      ev = h2;
`endif
      sets = ev;
      if (irq_timer_i) sets[0] = 1'b1;
      if (sgi_req_i) sets[sgi_code_bi] = 1'b1;
      avail = m_pend & irq_en_bi;
      if (m_req) begin
        if (irq_ack_i) begin
          m_pend[m_code] = 1'b0;
          m_req = 1'b0;
          m_hold = m_cyc + 2;
        end
      end else if (m_cyc >= m_hold && avail != 16'h0) begin
        for (int i = 15; i >= 0; i--) if (avail[i]) m_code = i;
        m_req = 1'b1;
      end
      m_pend = m_pend | sets;
      h3 = h2; h2 = h1; h1 = irq_bi;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("model_req", {31'd0, irq_req_o}, {31'd0, m_req});
      chk("model_pend", {16'd0, irq_pend_bo}, {16'd0, m_pend});
      if (m_req) chk("model_code", {28'd0, irq_code_bo}, m_code);
    end
  end

  task automatic wait_req(input string nm);
    int n = 0;
    while (!irq_req_o && n < 20) begin
      tick();
      n++;
    end
    chk(nm, {31'd0, irq_req_o}, 32'd1);
  endtask

  task automatic do_ack();
    irq_ack_i = 1'b1;
    tick();
    irq_ack_i = 1'b0;
  endtask

  task automatic drain(input int cycles, output int acks);
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      if (irq_req_o) begin
        irq_ack_i = 1'b1;
        acks++;
      end else begin
        irq_ack_i = 1'b0;
      end
      tick();
    end
    irq_ack_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int acks;
    repeat (3) tick();
    chk("rst_req", {31'd0, irq_req_o}, 32'd0);
    chk("rst_code", {28'd0, irq_code_bo}, 32'd0);
    chk("rst_pend", {16'd0, irq_pend_bo}, 32'd0);
    rst_i = 1'b1;
    cmp_on = 1'b1;
    tick();

    // Masked SGI latches pending but does not request
    sgi_req_i = 1'b1; sgi_code_bi = 4'd5;
    tick();
    sgi_req_i = 1'b0;
    chk("sgi5_pend", {16'd0, irq_pend_bo}, 32'h0020);
    repeat (3) tick();
    chk("sgi5_masked_req", {31'd0, irq_req_o}, 32'd0);
    irq_en_bi = 16'h0020;
    tick();
    chk("sgi5_en_req", {31'd0, irq_req_o}, 32'd1);
    chk("sgi5_en_code", {28'd0, irq_code_bo}, 32'd5);
    do_ack();
    chk("sgi5_ack_pend", {16'd0, irq_pend_bo}, 32'h0000);
    tick();

    // Timer and SGI 3 together: line 0 wins first
    irq_en_bi = 16'hFFFF;
    irq_timer_i = 1'b1; sgi_req_i = 1'b1; sgi_code_bi = 4'd3;
    tick();
    irq_timer_i = 1'b0; sgi_req_i = 1'b0;
    chk("both_pend", {16'd0, irq_pend_bo}, 32'h0009);
    chk("both_lat1_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    chk("both_first_code", {28'd0, irq_code_bo}, 32'd0);
    chk("both_first_req", {31'd0, irq_req_o}, 32'd1);
    do_ack();
    chk("both_ack1_pend", {16'd0, irq_pend_bo}, 32'h0008);
    tick();
    chk("both_gap_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    chk("both_second_req", {31'd0, irq_req_o}, 32'd1);
    chk("both_second_code", {28'd0, irq_code_bo}, 32'd3);
    do_ack();
    chk("both_ack2_pend", {16'd0, irq_pend_bo}, 32'h0000);
    repeat (2) tick();

    // Set and ack-clear on the same bit: set wins
    sgi_req_i = 1'b1; sgi_code_bi = 4'd2;
    tick();
    sgi_req_i = 1'b0;
    wait_req("coll_first_req");
    chk("coll_first_code", {28'd0, irq_code_bo}, 32'd2);
    irq_ack_i = 1'b1; sgi_req_i = 1'b1; sgi_code_bi = 4'd2;
    tick();
    irq_ack_i = 1'b0; sgi_req_i = 1'b0;
    chk("coll_pend_kept", {16'd0, irq_pend_bo}, 32'h0004);
    chk("coll_req_drop", {31'd0, irq_req_o}, 32'd0);
    tick();
    tick();
    chk("coll_rereq", {31'd0, irq_req_o}, 32'd1);
    chk("coll_rereq_code", {28'd0, irq_code_bo}, 32'd2);
    do_ack();
    chk("coll_final_pend", {16'd0, irq_pend_bo}, 32'h0000);
    repeat (2) tick();

    // External line 7 held high for 20 cycles, every request acked
    irq_bi[7] = 1'b1;
    drain(20, acks);
    irq_bi[7] = 1'b0;
    begin
      int more;
      drain(12, more);
      acks += more;
    end
`ifdef IRQ_PEND_CTRL_EDGE_DETECT_EN
    chk("line7_req_count", acks, 32'd1);
`else
    chk("line7_req_repeats", {31'd0, (acks >= 4)}, 32'd1);
`endif
    chk("line7_pend_clear", {16'd0, irq_pend_bo}, 32'h0000);

    // External rising edge latency on line 4
    irq_bi[4] = 1'b1;
    tick();
    chk("ext4_k0_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    chk("ext4_k1_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    chk("ext4_k2_pend", {16'd0, irq_pend_bo}, 32'h0010);
    chk("ext4_k2_req", {31'd0, irq_req_o}, 32'd0);
    tick();
    chk("ext4_k3_req", {31'd0, irq_req_o}, 32'd1);
    chk("ext4_k3_code", {28'd0, irq_code_bo}, 32'd4);
    irq_bi[4] = 1'b0;
    do_ack();
    drain(10, acks);
    chk("ext4_pend_clear", {16'd0, irq_pend_bo}, 32'h0000);

    // Asynchronous reset in the middle of a request
    irq_timer_i = 1'b1; sgi_req_i = 1'b1; sgi_code_bi = 4'd3;
    tick();
    irq_timer_i = 1'b0; sgi_req_i = 1'b0;
    tick();
    chk("mid_req_pre", {31'd0, irq_req_o}, 32'd1);
    chk("mid_pend_pre", {16'd0, irq_pend_bo}, 32'h0009);
    #2;
    rst_i = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, irq_req_o}, 32'd0);
    chk("async_rst_code", {28'd0, irq_code_bo}, 32'd0);
    chk("async_rst_pend", {16'd0, irq_pend_bo}, 32'd0);
    tick();
    rst_i = 1'b1;
    repeat (6) tick();
    chk("post_rst_req", {31'd0, irq_req_o}, 32'd0);
    chk("post_rst_pend", {16'd0, irq_pend_bo}, 32'd0);

    cmp_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
